// File: rtl/sprite_compositor.sv
// Sprite compositor: two-stage pixel pipeline that overlays NUM_SPR square
// sprites on a background and reports opaque sprite-to-sprite collisions.
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   frame_start          latches sprite shadow registers and collision report
//   pix_valid, col, row  current pixel position and visibility
//   spr_x/y/orient/en    live sprite attributes (slice i = sprite i)
//   rom_addr             registered per-sprite ROM address
//   rom_data             per-sprite ROM data, combinational from rom_addr
//   pix_out(_valid)      composited pixel, two cycles after the sampled pixel
//   coll_mask            per-sprite collision flags for the previous frame
module sprite_compositor #(
  parameter int unsigned      NUM_SPR    = 4,
  parameter int unsigned      SPR_W      = 32,
  parameter int unsigned      COL_W      = 10,
  parameter int unsigned      ROW_W      = 9,
  parameter int unsigned      PIX_W      = 12,
  parameter logic [PIX_W-1:0] TRANSP_KEY = 12'h000,
  parameter logic [PIX_W-1:0] BG_COLOR   = 12'h000,
  localparam int unsigned     AW         = 2 * $clog2(SPR_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [COL_W-1:0]         col,
  input  logic [ROW_W-1:0]         row,
  input  logic [NUM_SPR*COL_W-1:0] spr_x,
  input  logic [NUM_SPR*ROW_W-1:0] spr_y,
  input  logic [NUM_SPR*2-1:0]     spr_orient,
  input  logic [NUM_SPR-1:0]       spr_en,
  output logic [NUM_SPR*AW-1:0]    rom_addr,
  input  logic [NUM_SPR*PIX_W-1:0] rom_data,
  output logic [PIX_W-1:0]         pix_out,
  output logic                     pix_out_valid,
  output logic [NUM_SPR-1:0]       coll_mask
);

  localparam int unsigned LW = $clog2(SPR_W);
  localparam int unsigned XW = COL_W + 1;
  localparam int unsigned YW = ROW_W + 1;

  // Shadow sprite attributes, only updated on frame_start
  logic [NUM_SPR*COL_W-1:0] sx_q;
  logic [NUM_SPR*ROW_W-1:0] sy_q;
  logic [NUM_SPR*2-1:0]     so_q;
  logic [NUM_SPR-1:0]       sen_q;

  // Stage 1 registers
  logic [NUM_SPR*AW-1:0]    rom_addr_q, rom_addr_d;
  logic [NUM_SPR-1:0]       hit_q, hit_d;
  logic                     vld1_q;

  // Stage 2 registers and collision tracking
  logic [PIX_W-1:0]         pix_out_q, pix_out_d;
  logic                     pix_out_valid_q;
  logic [NUM_SPR-1:0]       acc_q, acc_d;
  logic [NUM_SPR-1:0]       coll_mask_q, coll_mask_d;

  logic [NUM_SPR-1:0]       opq;
  logic [NUM_SPR-1:0]       coll_set;
  logic [PIX_W-1:0]         sel;

  // Shadow register load
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q  <= '0;
      sy_q  <= '0;
      so_q  <= '0;
      sen_q <= '0;
    end else if (frame_start) begin
      sx_q  <= spr_x;
      sy_q  <= spr_y;
      so_q  <= spr_orient;
      sen_q <= spr_en;
    end
  end

  // Per-sprite hit test and ROM address generation
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [XW-1:0] x_e, c_e;
    logic [YW-1:0] y_e, r_e;
    logic [LW-1:0] dx, dy;
    logic          hit;
    logic [AW-1:0] addr;

    // One extra bit so a sprite near the right/bottom edge does not wrap
    assign x_e = XW'(sx_q[g*COL_W +: COL_W]);
    assign c_e = XW'(col);
    assign y_e = YW'(sy_q[g*ROW_W +: ROW_W]);
    assign r_e = YW'(row);

    assign hit = sen_q[g]
              && (c_e >= x_e) && (c_e < x_e + XW'(SPR_W))
              && (r_e >= y_e) && (r_e < y_e + YW'(SPR_W));

    assign dx = LW'(col - sx_q[g*COL_W +: COL_W]);
    assign dy = LW'(row - sy_q[g*ROW_W +: ROW_W]);

    // M - d is the bitwise complement of d because SPR_W is a power of two
    always_comb begin
      addr = '0;
      case (so_q[g*2 +: 2])
        2'd0:    addr = {dx, dy};
        2'd1:    addr = {dx, ~dy};
        2'd2:    addr = {dy, dx};
        default: addr = {dy, ~dx};
      endcase
      if (!hit) addr = '0;
    end

    assign rom_addr_d[g*AW +: AW] = addr;
    assign hit_d[g]               = hit;

    assign opq[g] = hit_q[g] && (rom_data[g*PIX_W +: PIX_W] != TRANSP_KEY);

    // Collides when opaque together with at least one other opaque sprite
    assign coll_set[g] = vld1_q && opq[g]
                      && ((opq & ~(NUM_SPR'(1) << g)) != '0);
  end

  // Stage 1: address, hit vector and pixel-valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit_q      <= '0;
      vld1_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_d;
      vld1_q     <= pix_valid;
    end
  end

  // Priority select: lowest-index opaque sprite wins
  always_comb begin
    sel = BG_COLOR;
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (opq[i]) sel = rom_data[i*PIX_W +: PIX_W];
    end
  end

  // Stage 2 next-state: pixel and collision bookkeeping
  always_comb begin
    pix_out_d   = vld1_q ? sel : '0;
    acc_d       = acc_q | coll_set;
    coll_mask_d = coll_mask_q;
    if (frame_start) begin
      coll_mask_d = acc_q | coll_set;
      acc_d       = '0;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out_q       <= '0;
      pix_out_valid_q <= 1'b0;
      acc_q           <= '0;
      coll_mask_q     <= '0;
    end else begin
      pix_out_q       <= pix_out_d;
      pix_out_valid_q <= vld1_q;
      acc_q           <= acc_d;
      coll_mask_q     <= coll_mask_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign pix_out       = pix_out_q;
  assign pix_out_valid = pix_out_valid_q;
  assign coll_mask     = coll_mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed vector table, directed
// multi-cycle sequences and randomized streaming against a behavioural model.
module tb_sprite_compositor;

  localparam int NS = 4;
  localparam int SW = 32;
  localparam int CW = 10;
  localparam int RW = 9;
  localparam int PW = 12;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_valid;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [NS*CW-1:0]  spr_x;
  logic [NS*RW-1:0]  spr_y;
  logic [NS*2-1:0]   spr_orient;
  logic [NS-1:0]     spr_en;
  logic [NS*AW-1:0]  rom_addr;
  logic [NS*PW-1:0]  rom_data;
  logic [PW-1:0]     pix_out;
  logic              pix_out_valid;
  logic [NS-1:0]     coll_mask;

  always #5 clk = ~clk;

  sprite_compositor #(
    .NUM_SPR(NS), .SPR_W(SW), .COL_W(CW), .ROW_W(RW), .PIX_W(PW),
    .TRANSP_KEY(12'h000), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .col(col), .row(row), .spr_x(spr_x), .spr_y(spr_y),
    .spr_orient(spr_orient), .spr_en(spr_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_out(pix_out), .pix_out_valid(pix_out_valid),
    .coll_mask(coll_mask)
  );

  // Asynchronous sprite ROMs
  logic [PW-1:0] rom_mem [NS][1024];
  for (genvar g = 0; g < NS; g++) begin : g_rom
    assign rom_data[g*PW +: PW] = rom_mem[g][rom_addr[g*AW +: AW]];
  end

  // Behavioural model state
  int        m_x [NS];
  int        m_y [NS];
  int        m_o [NS];
  bit        m_en[NS];
  int        s1_addr[NS];
  bit        s1_hit [NS];
  bit        s1_vld;
  int        o_pix;
  bit        o_vld;
  bit [NS-1:0] acc;
  bit [NS-1:0] coll;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_o[i] = 0; m_en[i] = 0;
      s1_addr[i] = 0; s1_hit[i] = 0;
    end
    s1_vld = 0; o_pix = 0; o_vld = 0; acc = '0; coll = '0;
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare outputs
  task automatic tick();
    int          n_addr[NS];
    bit          n_hit[NS];
    bit [NS-1:0] opq, cs;
    int          nop, n_pix, c, r, dx, dy;
    int          lx[NS], ly[NS], lo[NS];
    bit          len[NS];
    bit          fs, pv, rs;
    fs = frame_start; pv = pix_valid; rs = rst;
    c = int'(col); r = int'(row);
    for (int i = 0; i < NS; i++) begin
      lx[i]  = int'(spr_x[i*CW +: CW]);
      ly[i]  = int'(spr_y[i*RW +: RW]);
      lo[i]  = int'(spr_orient[i*2 +: 2]);
      len[i] = spr_en[i];
    end
    // Output stage from the previously sampled pixel
    opq = '0; nop = 0; n_pix = 0;
    for (int i = 0; i < NS; i++) begin
      opq[i] = s1_hit[i] && (rom_mem[i][s1_addr[i]] != 12'h000);
      if (opq[i]) nop++;
    end
    for (int i = NS - 1; i >= 0; i--) if (opq[i]) n_pix = int'(rom_mem[i][s1_addr[i]]);
    if (!s1_vld) n_pix = 0;
    for (int i = 0; i < NS; i++) cs[i] = s1_vld && opq[i] && (nop >= 2);
    // Address stage from the current pixel and the shadow attributes
    for (int i = 0; i < NS; i++) begin
      n_hit[i] = m_en[i] && (c >= m_x[i]) && (c < m_x[i] + SW)
                         && (r >= m_y[i]) && (r < m_y[i] + SW);
      dx = c - m_x[i];
      dy = r - m_y[i];
      case (m_o[i])
        0:       n_addr[i] = dx * SW + dy;
        1:       n_addr[i] = dx * SW + (SW - 1 - dy);
        2:       n_addr[i] = dy * SW + dx;
        default: n_addr[i] = dy * SW + (SW - 1 - dx);
      endcase
      if (!n_hit[i]) n_addr[i] = 0;
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      o_pix = n_pix;
      o_vld = s1_vld;
      if (fs) begin
        coll = acc | cs;
        acc  = '0;
      end else begin
        acc = acc | cs;
      end
      for (int i = 0; i < NS; i++) begin
        s1_addr[i] = n_addr[i];
        s1_hit[i]  = n_hit[i];
      end
      s1_vld = pv;
      if (fs) begin
        for (int i = 0; i < NS; i++) begin
          m_x[i] = lx[i]; m_y[i] = ly[i]; m_o[i] = lo[i]; m_en[i] = len[i];
        end
      end
    end
    #1;
    for (int i = 0; i < NS; i++)
      chk($sformatf("rom_addr%0d", i), int'(rom_addr[i*AW +: AW]), s1_addr[i]);
    chk("pix_out", int'(pix_out), o_pix);
    chk("pix_out_valid", int'(pix_out_valid), int'(o_vld));
    chk("coll_mask", int'(coll_mask), int'(coll));
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int o, input bit en);
    spr_x[i*CW +: CW]    = CW'(x);
    spr_y[i*RW +: RW]    = RW'(y);
    spr_orient[i*2 +: 2] = 2'(o);
    spr_en[i]            = en;
  endtask

  task automatic pixel(input int c, input int r);
    col = CW'(c); row = RW'(r); pix_valid = 1'b1;
  endtask

  typedef struct {
    int o; int x; int y; int c; int r; int exp_addr; bit exp_hit;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2, 100, 50, 103, 52,   67, 1'b1};
    tbl[1] = '{0, 100, 50, 103, 52,   98, 1'b1};
    tbl[2] = '{1, 100, 50, 103, 52,  125, 1'b1};
    tbl[3] = '{3, 100, 50, 103, 52,   92, 1'b1};
    tbl[4] = '{0, 1010, 50, 1020, 52, 322, 1'b1};
    tbl[5] = '{0, 1010, 50, 5, 52,     0, 1'b0};
    tbl[6] = '{0, 100, 50, 131, 81, 1023, 1'b1};
    tbl[7] = '{0, 100, 50, 132, 52,    0, 1'b0};
    tbl[8] = '{0, 100, 50, 103, 82,    0, 1'b0};
    tbl[9] = '{0, 100, 50, 99, 52,     0, 1'b0};

    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    col = '0; row = '0; spr_x = '0; spr_y = '0; spr_orient = '0; spr_en = '0;
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 1024; a++) rom_mem[i][a] = 12'($urandom_range(1, 4095));
    model_reset();

    // Reset, with frame_start and pix_valid also asserted
    frame_start = 1'b1; pix_valid = 1'b1; spr_en = '1;
    tick(); tick();
    chk("reset_pix", int'(pix_out), 0);
    chk("reset_vld", int'(pix_out_valid), 0);
    chk("reset_coll", int'(coll_mask), 0);
    chk("reset_addr", int'(rom_addr), 0);
    rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; spr_en = '0;
    tick();

    // Vector table: orientation mapping and hit boundaries on sprite 0
    for (int k = 0; k < 10; k++) begin
      set_spr(0, tbl[k].x, tbl[k].y, tbl[k].o, 1'b1);
      frame_start = 1'b1; pix_valid = 1'b0;
      tick();
      frame_start = 1'b0;
      pixel(tbl[k].c, tbl[k].r);
      tick();
      chk($sformatf("tbl%0d_addr", k), int'(rom_addr[0 +: AW]), tbl[k].exp_addr);
      pix_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_pix", k), int'(pix_out),
          tbl[k].exp_hit ? int'(rom_mem[0][tbl[k].exp_addr]) : 0);
      chk($sformatf("tbl%0d_vld", k), int'(pix_out_valid), 1);
    end

    // Priority and collision: sprites 0 and 1 stacked at (200,100)
    set_spr(0, 200, 100, 0, 1'b1);
    set_spr(1, 200, 100, 0, 1'b1);
    rom_mem[0][163] = 12'h000;
    rom_mem[1][163] = 12'hABC;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel(205, 103); tick();
    pix_valid = 1'b0; tick();
    chk("transp_pix", int'(pix_out), 12'hABC);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("coll_none", int'(coll_mask), 0);
    rom_mem[0][163] = 12'h123;
    pixel(205, 103); tick();
    pix_valid = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("prio_pix", int'(pix_out), 12'h123);
    chk("coll_both", int'(coll_mask), 3);
    tick(); tick();
    chk("coll_hold", int'(coll_mask), 3);
    frame_start = 1'b1; tick(); tick(); frame_start = 1'b0;
    chk("coll_clear", int'(coll_mask), 0);

    // Shadowing: live changes ignored until frame_start
    set_spr(1, 0, 0, 0, 1'b0);
    set_spr(0, 300, 200, 0, 1'b1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel(305, 202); tick();
    chk("shadow_base", int'(rom_addr[0 +: AW]), 162);
    set_spr(0, 302, 200, 0, 1'b1);
    tick();
    chk("shadow_live", int'(rom_addr[0 +: AW]), 162);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("shadow_same", int'(rom_addr[0 +: AW]), 162);
    tick();
    chk("shadow_next", int'(rom_addr[0 +: AW]), 98);

    // Reset while streaming flushes the pipe and disables sprites
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_pix", int'(pix_out), 0);
    chk("rst_vld", int'(pix_out_valid), 0);
    chk("rst_coll", int'(coll_mask), 0);
    pix_valid = 1'b0; tick();
    pixel(305, 202); tick();
    chk("rst_addr", int'(rom_addr[0 +: AW]), 0);
    chk("rst_vld1", int'(pix_out_valid), 0);
    pix_valid = 1'b0; tick();
    chk("rst_vld2", int'(pix_out_valid), 1);
    chk("rst_bg", int'(pix_out), 0);

    // Randomized streaming against the model
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 1024; a++)
        rom_mem[i][a] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
    for (int n = 0; n < 3000; n++) begin
      bit edge_mode;
      edge_mode = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NS; i++) begin
        if (edge_mode)
          set_spr(i, $urandom_range(990, 1023), $urandom_range(20, 60),
                  $urandom_range(0, 3), $urandom_range(0, 4) != 0);
        else
          set_spr(i, $urandom_range(40, 100), $urandom_range(20, 70),
                  $urandom_range(0, 3), $urandom_range(0, 4) != 0);
      end
      frame_start = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 600) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) col = CW'($urandom_range(980, 1023));
      else                           col = CW'($urandom_range(30, 140));
      row = RW'($urandom_range(10, 110));
      tick();
    end
    rst = 1'b0; frame_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
